hazard_stall_ctrl: RTL and testbench

Pipeline hazard and multiply/divide sequencing controller for the five-stage MIPS core. Sits beside the decode stage. Each cycle it decides whether the instruction in D must be held:
- combines register-dependency checks on Tuse/Tnew;
- tracks the multi-cycle mult/div unit with an internal busy state machine.

It drives the hold input of the F-to-D pipeline register and the PC enable, the flush of the D-to-E register, and a saturating stall-cycle counter for performance checks.

---
 rtl/hazard_stall_ctrl_pkg.sv | 18 +
 rtl/hazard_stall_ctrl_md_busy_fsm.sv | 66 ++++++
 rtl/hazard_stall_ctrl.sv | 70 +++++++
 tb/tb_hazard_stall_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the hazard/stall controller and the mult/div datapath.
package hazard_stall_ctrl_pkg;

    // Mult/div sequencing states
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2
    } md_state_e;

    // Tuse value meaning the source register is never read
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Latencies of the mult/div datapath, shared with the datapath itself
    localparam int unsigned MD_MULT_CYCLES = 5;
    localparam int unsigned MD_DIV_CYCLES  = 10;

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_fsm.sv
// Occupancy tracker for the multi-cycle mult/div unit.
// md_busy and md_done come straight from flops.
module hazard_stall_ctrl_md_busy_fsm
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES,
    parameter int unsigned CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start_E,
    input  logic md_is_div_E,
    output logic md_busy,
    output logic md_done
);

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;

    // State, down-counter and registered busy/done flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (md_start_E) begin
                        state_q <= md_is_div_E ? MD_DIV : MD_MULT;
                        cnt_q   <= md_is_div_E ? CNT_W'(DIV_CYCLES - 1)
                                               : CNT_W'(MULT_CYCLES - 1);
                        busy_q  <= 1'b1;
                        // Single-cycle latency finishes in the very next cycle
                        done_q  <= md_is_div_E ? (DIV_CYCLES == 1) : (MULT_CYCLES == 1);
                    end
                end
                MD_MULT, MD_DIV: begin
                    // Starts arriving while occupied are ignored
                    if (cnt_q != '0) begin
                        cnt_q  <= cnt_q - CNT_W'(1);
                        done_q <= (cnt_q == CNT_W'(1));
                    end else begin
                        state_q <= MD_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= MD_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign md_busy = busy_q;
    assign md_done = done_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage hazard controller: data-dependency stalls from Tuse/Tnew,
// mult/div occupancy stalls, and a saturating stall-cycle counter.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  tuse_rs_D,
    input  logic [1:0]  tuse_rt_D,
    input  logic [4:0]  a3_E,
    input  logic [4:0]  a3_M,
    input  logic [1:0]  tnew_E,
    input  logic [1:0]  tnew_M,
    input  logic        md_use_D,
    input  logic        md_start_E,
    input  logic        md_is_div_E,
    output logic        stall,
    output logic        flush_E,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_count
);

    logic        data_stall;
    logic        md_stall;
    logic [31:0] stall_count_q;

    hazard_stall_ctrl_md_busy_fsm #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_fsm (
        .clk         (clk),
        .reset       (reset),
        .md_start_E  (md_start_E),
        .md_is_div_E (md_is_div_E),
        .md_busy     (md_busy),
        .md_done     (md_done)
    );

    // Stall when a producer in E/M cannot deliver before D needs the value
    always_comb begin
        data_stall = 1'b0;
        if ((rs_D == a3_E) && (a3_E != 5'd0) && (tuse_rs_D < tnew_E)) data_stall = 1'b1;
        if ((rs_D == a3_M) && (a3_M != 5'd0) && (tuse_rs_D < tnew_M)) data_stall = 1'b1;
        if ((rt_D == a3_E) && (a3_E != 5'd0) && (tuse_rt_D < tnew_E)) data_stall = 1'b1;
        if ((rt_D == a3_M) && (a3_M != 5'd0) && (tuse_rt_D < tnew_M)) data_stall = 1'b1;
        md_stall = md_use_D & (md_start_E | md_busy);
        stall    = data_stall | md_stall;
        flush_E  = data_stall | md_stall;
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
        end else if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: a cycle-level reference model
// checked every negedge, plus directed vectors with literal expectations.
module tb_hazard_stall_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  rs_D, rt_D, a3_E, a3_M;
    logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
    logic        md_use_D, md_start_E, md_is_div_E;
    logic        stall, flush_E, md_busy, md_done;
    logic [31:0] stall_count;

    int checks = 0;
    int errors = 0;

    hazard_stall_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rs_D        (rs_D),
        .rt_D        (rt_D),
        .tuse_rs_D   (tuse_rs_D),
        .tuse_rt_D   (tuse_rt_D),
        .a3_E        (a3_E),
        .a3_M        (a3_M),
        .tnew_E      (tnew_E),
        .tnew_M      (tnew_M),
        .md_use_D    (md_use_D),
        .md_start_E  (md_start_E),
        .md_is_div_E (md_is_div_E),
        .stall       (stall),
        .flush_E     (flush_E),
        .md_busy     (md_busy),
        .md_done     (md_done),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          model_rem   = 0;   // busy cycles still to come, including the current one
    logic [31:0] model_cnt   = 0;
    bit          model_valid = 0;

    function automatic bit model_stall();
        logic [4:0] src [2];
        logic [1:0] tuse [2];
        logic [4:0] dst [2];
        logic [1:0] tnew [2];
        bit s;
        src[0] = rs_D; src[1] = rt_D; tuse[0] = tuse_rs_D; tuse[1] = tuse_rt_D;
        dst[0] = a3_E; dst[1] = a3_M; tnew[0] = tnew_E;    tnew[1] = tnew_M;
        s = md_use_D && (md_start_E || model_rem > 0);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                if (src[i] == dst[j] && dst[j] != 0 && int'(tuse[i]) < int'(tnew[j])) s = 1;
        return s;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            model_rem   = 0;
            model_cnt   = 0;
            model_valid = 1;
        end else if (model_valid) begin
            if (model_stall() && model_cnt != 32'hFFFF_FFFF) model_cnt = model_cnt + 1;
            if (model_rem > 0) model_rem = model_rem - 1;
            else if (md_start_E) model_rem = md_is_div_E ? 10 : 5;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("model_stall", {31'd0, stall}, {31'd0, model_stall()});
            check("model_flush", {31'd0, flush_E}, {31'd0, model_stall()});
            check("model_busy", {31'd0, md_busy}, {31'd0, model_rem > 0});
            check("model_done", {31'd0, md_done}, {31'd0, model_rem == 1});
            check("model_count", stall_count, model_cnt);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs_D = 0; rt_D = 0; a3_E = 0; a3_M = 0;
        tuse_rs_D = 2'd3; tuse_rt_D = 2'd3; tnew_E = 0; tnew_M = 0;
        md_use_D = 0; md_start_E = 0; md_is_div_E = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    initial begin
        idle_inputs();
        do_reset();
        #1;
        check("rst_busy", {31'd0, md_busy}, 32'd0);
        check("rst_done", {31'd0, md_done}, 32'd0);
        check("rst_count", stall_count, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);

        // Load-use against E
        tick();
        rs_D = 5; tuse_rs_D = 0; a3_E = 5; tnew_E = 2; #1;
        check("loaduse_stall", {31'd0, stall}, 32'd1);
        check("loaduse_flush", {31'd0, flush_E}, 32'd1);
        a3_E = 0; #1;
        check("loaduse_a3zero", {31'd0, stall}, 32'd0);
        idle_inputs();

        // Forwardable from M, then not forwardable
        tick();
        rt_D = 8; tuse_rt_D = 1; a3_M = 8; tnew_M = 1; #1;
        check("fwd_m_nostall", {31'd0, stall}, 32'd0);
        tuse_rt_D = 0; #1;
        check("fwd_m_stall", {31'd0, stall}, 32'd1);
        idle_inputs();

        // Mult; stray starts in cycle 3 (busy) and cycle 5 (done) are ignored
        tick();
        md_use_D = 1; md_start_E = 1; md_is_div_E = 0; #1;
        check("mult_c0_stall", {31'd0, stall}, 32'd1);
        check("mult_c0_busy", {31'd0, md_busy}, 32'd0);
        for (int c = 1; c <= 6; c++) begin
            tick();
            md_start_E = (c == 3) || (c == 5);
            md_is_div_E = (c == 3);
            #1;
            check($sformatf("mult_c%0d_busy", c), {31'd0, md_busy}, {31'd0, c <= 5});
            check($sformatf("mult_c%0d_done", c), {31'd0, md_done}, {31'd0, c == 5});
            check($sformatf("mult_c%0d_stall", c), {31'd0, stall}, {31'd0, c <= 5});
        end
        idle_inputs();

        // Div with a non-MD instruction in D
        tick();
        md_start_E = 1; md_is_div_E = 1; #1;
        check("div_c0_stall", {31'd0, stall}, 32'd0);
        for (int c = 1; c <= 11; c++) begin
            tick();
            md_start_E = 0; #1;
            check($sformatf("div_c%0d_busy", c), {31'd0, md_busy}, {31'd0, c <= 10});
            check($sformatf("div_c%0d_done", c), {31'd0, md_done}, {31'd0, c == 10});
            check($sformatf("div_c%0d_stall", c), {31'd0, stall}, 32'd0);
        end

        // Reset in the middle of a div, then a fresh div
        tick();
        md_start_E = 1; md_is_div_E = 1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            md_start_E = (c == 6);
            reset = (c == 4);
            #1;
            if (c == 5) check("rstdiv_count", stall_count, 32'd0);
            check($sformatf("rstdiv_c%0d_busy", c), {31'd0, md_busy},
                  {31'd0, (c <= 4) || (c >= 7)});
            check($sformatf("rstdiv_c%0d_done", c), {31'd0, md_done}, {31'd0, c == 16});
        end
        tick();
        check("rstdiv_after_busy", {31'd0, md_busy}, 32'd0);
        idle_inputs();

        // Counter: 7 stalled cycles after a reset
        do_reset();
        rs_D = 5; tuse_rs_D = 0; a3_E = 5; tnew_E = 2;
        for (int c = 0; c < 7; c++) tick();
        idle_inputs(); #1;
        check("count_seven", stall_count, 32'd7);

        // Saturation from FFFF_FFFE with 3 stalled cycles
        tick();
        force dut.stall_count_q = 32'hFFFF_FFFE;
        model_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.stall_count_q;
        rt_D = 9; tuse_rt_D = 0; a3_M = 9; tnew_M = 1;
        tick();
        check("sat_step1", stall_count, 32'hFFFF_FFFF);
        tick();
        tick();
        idle_inputs(); #1;
        check("sat_hold", stall_count, 32'hFFFF_FFFF);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
